// File: rtl/if_stage_prefetch.sv
// Prefetching instruction-fetch stage: pipelined imem requests under a credit limit,
// a {pc, instr} prefetch FIFO toward decode, and redirect flushing of stale responses.
module if_stage_prefetch #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     PC_STEP    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PC_Branch,
    input  logic            ID_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            IF_valid,
    output logic [XLEN-1:0] PC_IF,
    output logic [XLEN-1:0] INSTRUCTION_IF
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W  = CNT_W + 1;
    // Stale responses can outnumber the FIFO after back-to-back redirects.
    localparam int unsigned DISC_W = CNT_W + 3;

    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(FIFO_DEPTH);
    localparam logic [XLEN-1:0]  STEP    = XLEN'(PC_STEP);

    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   fifo_pc  [FIFO_DEPTH];
    logic [XLEN-1:0]   fifo_ins [FIFO_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [XLEN-1:0]   pq_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]  pq_head;
    logic [PTR_W-1:0]  pq_tail;
    logic [CNT_W-1:0]  live;
    logic [DISC_W-1:0] discard;

    logic has_head;
    logic resp_any;
    logic resp_drop;
    logic resp_keep;
    logic issue;
    logic pop;

    always_comb begin
        has_head       = (count != '0);
        resp_any       = imem_rvalid && ((live != '0) || (discard != '0));
        resp_drop      = imem_rvalid && (discard != '0);
        resp_keep      = resp_any && !resp_drop;
        issue          = reset && !PCSrc && (({1'b0, count} + {1'b0, live}) < DEPTH_S);
        IF_valid       = has_head && !PCSrc;
        pop            = IF_valid && ID_ready;
        imem_req       = issue;
        imem_addr      = fetch_pc;
        PC_IF          = has_head ? fifo_pc[head]  : '0;
        INSTRUCTION_IF = has_head ? fifo_ins[head] : '0;
    end

    // The pc queue holds live requests only: dropped responses need no address,
    // so a redirect just clears it while discard tracks what is still in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            pq_head  <= '0;
            pq_tail  <= '0;
            live     <= '0;
            discard  <= '0;
        end else if (PCSrc) begin
            fetch_pc <= PC_Branch;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            pq_head  <= '0;
            pq_tail  <= '0;
            live     <= '0;
            discard  <= discard + DISC_W'(live) - DISC_W'(resp_any);
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + STEP;
                pq_tail  <= pq_tail + 1'b1;
            end
            if (resp_keep) begin
                pq_head <= pq_head + 1'b1;
                tail    <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (resp_drop) begin
                discard <= discard - 1'b1;
            end
            live  <= live + CNT_W'(issue) - CNT_W'(resp_keep);
            count <= count + CNT_W'(resp_keep) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            pq_pc[pq_tail] <= fetch_pc;
        end
        if (reset && !PCSrc && resp_keep) begin
            fifo_pc[tail]  <= pq_pc[pq_head];
            fifo_ins[tail] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Bench for if_stage_prefetch: in-order variable-latency memory, queue-based reference
// model, a directed vector table, redirect/wrap sequences and a randomized run.
module tb_if_stage_prefetch;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] STEP   = 32'd4;

    logic            clk = 1'b0;
    logic            reset;
    logic            PCSrc;
    logic [XLEN-1:0] PC_Branch;
    logic            ID_ready;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            IF_valid;
    logic [XLEN-1:0] PC_IF;
    logic [XLEN-1:0] INSTRUCTION_IF;

    if_stage_prefetch #(
        .XLEN      (XLEN),
        .FIFO_DEPTH(DEPTH),
        .RESET_PC  (RST_PC),
        .PC_STEP   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .PCSrc         (PCSrc),
        .PC_Branch     (PC_Branch),
        .ID_ready      (ID_ready),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .IF_valid      (IF_valid),
        .PC_IF         (PC_IF),
        .INSTRUCTION_IF(INSTRUCTION_IF)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        bit          stale;
        int unsigned due;
    } infl_t;

    typedef struct {
        bit          rst_n;
        bit          src;
        logic [31:0] tgt;
        bit          idr;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    ent_t        m_fifo[$];
    infl_t       m_infl[$];
    vec_t        vecs[$];
    logic [31:0] m_fetch;
    bit          model_known;
    int unsigned cyc;
    int unsigned lat_min;
    int unsigned lat_max;
    int          n_cmp;
    int          n_err;

    logic        s_req;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [31:0] s_ins;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs and memory response, compare against the model,
    // advance the model across the edge, then move to just after the next edge.
    task automatic step(input bit rst_n, input bit src, input logic [31:0] tgt, input bit idr);
        bit          rv;
        logic [31:0] rd;
        infl_t       e;
        infl_t       n;
        ent_t        w;
        int unsigned live;
        int unsigned due;
        bit          m_req;
        bit          m_valid;
        logic [31:0] m_pc;
        logic [31:0] m_ins;

        rv = 1'b0;
        rd = '0;
        if (rst_n && m_infl.size() > 0 && m_infl[0].due <= cyc) begin
            rv = 1'b1;
            rd = instr_of(m_infl[0].pc);
        end
        reset       = rst_n;
        PCSrc       = src;
        PC_Branch   = tgt;
        ID_ready    = idr;
        imem_rvalid = rv;
        imem_rdata  = rv ? rd : $urandom();
        #3;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = IF_valid;
        s_pc    = PC_IF;
        s_ins   = INSTRUCTION_IF;

        live = 0;
        foreach (m_infl[i]) if (!m_infl[i].stale) live++;
        m_req   = rst_n && !src && (m_fifo.size() + live < DEPTH);
        m_valid = (m_fifo.size() > 0) && !src;
        m_pc    = (m_fifo.size() > 0) ? m_fifo[0].pc  : 32'h0;
        m_ins   = (m_fifo.size() > 0) ? m_fifo[0].ins : 32'h0;

        if (model_known) begin
            check("imem_req", 32'(s_req), 32'(m_req));
            if (m_req) check("imem_addr", s_addr, m_fetch);
            check("IF_valid", 32'(s_valid), 32'(m_valid));
            check("PC_IF", s_pc, m_pc);
            check("INSTRUCTION_IF", s_ins, m_ins);
        end

        if (!rst_n) begin
            m_fifo.delete();
            m_infl.delete();
            m_fetch     = RST_PC;
            model_known = 1'b1;
        end else begin
            if (rv) e = m_infl.pop_front();
            if (src) begin
                m_fifo.delete();
                foreach (m_infl[i]) m_infl[i].stale = 1'b1;
                m_fetch = tgt;
            end else begin
                if (m_valid && idr) void'(m_fifo.pop_front());
                if (rv && !e.stale) begin
                    w.pc  = e.pc;
                    w.ins = rd;
                    m_fifo.push_back(w);
                end
                if (m_req) begin
                    due = cyc + $urandom_range(lat_max, lat_min);
                    if (m_infl.size() > 0 && m_infl[m_infl.size()-1].due >= due)
                        due = m_infl[m_infl.size()-1].due + 1;
                    n.pc    = m_fetch;
                    n.stale = 1'b0;
                    n.due   = due;
                    m_infl.push_back(n);
                    m_fetch = m_fetch + STEP;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            n++;
        end while (!s_valid && n < 20);
    endtask

    task automatic add(input bit rst_n, input bit src, input bit idr,
                       input bit e_req, input logic [31:0] e_addr,
                       input bit e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.rst_n   = rst_n;
        v.src     = src;
        v.tgt     = 32'h0;
        v.idr     = idr;
        v.e_req   = e_req;
        v.e_addr  = e_addr;
        v.e_valid = e_valid;
        v.e_pc    = e_pc;
        vecs.push_back(v);
    endtask

    initial begin
        int          n;
        bit          r_rst;
        bit          r_src;
        bit          r_idr;
        logic [31:0] r_tgt;

        n_cmp       = 0;
        n_err       = 0;
        cyc         = 0;
        model_known = 1'b0;
        lat_min     = 1;
        lat_max     = 1;
        m_fetch     = RST_PC;
        reset       = 1'b0;
        PCSrc       = 1'b0;
        PC_Branch   = '0;
        ID_ready    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;

        // 1-cycle memory: reset release with steady drain, stall, mid-stream reset,
        // stall from empty (exactly 4 requests), then drain and resume at 16.
        add(0, 0, 1, 0, 32'h0,  0, 32'h0);
        add(1, 0, 1, 1, 32'h0,  0, 32'h0);
        add(1, 0, 1, 1, 32'h4,  0, 32'h0);
        add(1, 0, 1, 1, 32'h8,  1, 32'h0);
        add(1, 0, 1, 1, 32'hC,  1, 32'h4);
        add(1, 0, 1, 1, 32'h10, 1, 32'h8);
        add(1, 0, 0, 1, 32'h14, 1, 32'hC);
        add(1, 0, 0, 1, 32'h18, 1, 32'hC);
        for (int i = 0; i < 8; i++) add(1, 0, 0, 0, 32'h0, 1, 32'hC);
        add(0, 0, 1, 0, 32'h0,  1, 32'hC);
        add(0, 0, 0, 0, 32'h0,  0, 32'h0);
        add(1, 0, 0, 1, 32'h0,  0, 32'h0);
        add(1, 0, 0, 1, 32'h4,  0, 32'h0);
        add(1, 0, 0, 1, 32'h8,  1, 32'h0);
        add(1, 0, 0, 1, 32'hC,  1, 32'h0);
        for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 32'h0, 1, 32'h0);
        add(1, 0, 1, 0, 32'h0,  1, 32'h0);
        add(1, 0, 1, 1, 32'h10, 1, 32'h4);
        add(1, 0, 1, 1, 32'h14, 1, 32'h8);
        add(1, 0, 1, 1, 32'h18, 1, 32'hC);
        add(1, 0, 1, 1, 32'h1C, 1, 32'h10);

        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].src, vecs[i].tgt, vecs[i].idr);
            check($sformatf("tbl[%0d].req", i), 32'(s_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) check($sformatf("tbl[%0d].addr", i), s_addr, vecs[i].e_addr);
            check($sformatf("tbl[%0d].valid", i), 32'(s_valid), 32'(vecs[i].e_valid));
            check($sformatf("tbl[%0d].pc", i), s_pc, vecs[i].e_pc);
            if (vecs[i].e_valid) check($sformatf("tbl[%0d].instr", i), s_ins, instr_of(vecs[i].e_pc));
        end

        // 3-cycle memory, two requests in flight, redirect to 0x100.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        lat_min = 3;
        lat_max = 3;
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h100, 1'b1);
        check("redir3.req_in_redirect", 32'(s_req), 32'h0);
        check("redir3.valid_in_redirect", 32'(s_valid), 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("redir3.req_after", 32'(s_req), 32'h1);
        check("redir3.addr_after", s_addr, 32'h100);
        wait_valid(n);
        check("redir3.first_valid_delay", 32'(n), 32'd4);
        check("redir3.first_pc", s_pc, 32'h100);
        check("redir3.first_instr", s_ins, instr_of(32'h100));

        // 2-cycle memory at full rate: redirect lands with a response and a pending pop.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        lat_min = 2;
        lat_max = 2;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        check("redir2.valid_before", 32'(s_valid), 32'h1);
        step(1'b1, 1'b1, 32'h200, 1'b1);
        check("redir2.valid_in_redirect", 32'(s_valid), 32'h0);
        check("redir2.req_in_redirect", 32'(s_req), 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("redir2.addr_after", s_addr, 32'h200);
        wait_valid(n);
        check("redir2.first_valid_delay", 32'(n), 32'd3);
        check("redir2.first_pc", s_pc, 32'h200);
        check("redir2.first_instr", s_ins, instr_of(32'h200));

        // Address wrap near the top of the PC space.
        lat_min = 1;
        lat_max = 1;
        step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap.addr0", s_addr, 32'hFFFF_FFF8);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap.addr1", s_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap.req2", 32'(s_req), 32'h1);
        check("wrap.addr2", s_addr, 32'h0);

        // Randomized traffic against the reference model.
        for (int seg = 0; seg < 6; seg++) begin
            lat_min = 1;
            lat_max = $urandom_range(4, 1);
            for (int k = 0; k < 500; k++) begin
                r_rst = ($urandom_range(199, 0) != 0);
                r_src = ($urandom_range(24, 0) == 0);
                r_idr = ($urandom_range(9, 0) < 7);
                r_tgt = $urandom() & 32'hFFFF_FFFC;
                if ($urandom_range(3, 0) == 0) r_tgt = 32'hFFFF_FFF0 | ($urandom() & 32'hC);
                step(r_rst, r_src, r_tgt, r_idr);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
